// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encoding, register constants
// and the source/destination compare helper used by the hazard logic.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  // sll $zero,$zero,0 -- what ID/EXE loads when bubble_id is asserted
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // A source only matters if it is read and is not the hardwired $zero
  function automatic logic src_match(input logic [4:0] src, input logic used,
                                     input logic [4:0] dest);
    return used && (src != REG_ZERO) && (src == dest);
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/bubble/flush sequencing for the 5-stage core: load-use and RAW hazard detection,
// SRAM-wait freeze with timeout trap, branch flush arbitration and stall/bubble statistics.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             br_taken,
  output logic             freeze_front,
  output logic             bubble_id,
  output logic             freeze_all,
  output logic             flush_if,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [1:0]       fsm_state
);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        src1_used, src2_used;
  logic        hz_exe, hz_mem, hazard;
  logic        raw_freeze_all, raw_freeze_front, raw_bubble, raw_flush;

  assign src1_used = id_valid;
  assign src2_used = id_valid & id_two_src;
  assign hz_exe = exe_wb_en & (src_match(id_src1, src1_used, exe_dest) |
                               src_match(id_src2, src2_used, exe_dest));
  assign hz_mem = mem_wb_en & (src_match(id_src1, src1_used, mem_dest) |
                               src_match(id_src2, src2_used, mem_dest));
  // With forwarding only a load in EXE cannot be bypassed in time
  assign hazard = fwd_en ? (hz_exe & exe_mem_r_en) : (hz_exe | hz_mem);

  always_comb begin
    raw_freeze_all   = 1'b0;
    raw_freeze_front = 1'b0;
    raw_bubble       = 1'b0;
    raw_flush        = 1'b0;
    case (state)
      ST_RUN:   raw_freeze_all = mem_req & ~sram_ready;
      ST_MWAIT: raw_freeze_all = ~sram_ready;
      default:  raw_freeze_all = 1'b1;
    endcase
    // A full freeze overrides everything; a hazard suppresses the (stale) branch
    if (!raw_freeze_all) begin
      raw_freeze_front = hazard;
      raw_bubble       = hazard;
      raw_flush        = ~hazard & br_taken;
    end
  end

  assign freeze_all   = raw_freeze_all & ~rst;
  assign freeze_front = raw_freeze_front & ~rst;
  assign bubble_id    = raw_bubble & ~rst;
  assign flush_if     = raw_flush & ~rst;
  assign fsm_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req && !sram_ready) begin
            state    <= ST_MWAIT;
            wait_cnt <= 16'd1;
          end
        end
        ST_MWAIT: begin
          if (sram_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == 16'(MEM_TIMEOUT)) begin
            state     <= ST_FAULT;
            mem_fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_FAULT: mem_fault <= 1'b1;
        default:  state <= ST_RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze_front | freeze_all),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_id),
    .count (bubble_count)
  );

endmodule
